// File: rtl/pipeline_controller_if.sv
// Control-side bundle between the MIPS datapath and pipeline_controller.
// The datapath (master) supplies instruction fields, stage destination
// registers and the MEM-stage zero flag; the controller (slave) returns the
// per-stage control word, redirect, forwarding selects and the illegal flag.
interface pipeline_controller_if;
   // Instruction fields of the IF/ID instruction
   logic [5:0] op;
   logic [5:0] func;
   logic [4:0] rs;
   logic [4:0] rt;
   // Destination registers of the MEM and WB stages, and the MEM zero flag
   logic [4:0] write_adress_reg_out;
   logic [4:0] write_adress_reg2_out;
   logic       zero_reg_out;
   // EX controls
   logic [2:0] ALUop2;
   logic       ALUsrc2;
   logic [1:0] RegDest2;
   // MEM controls
   logic       MemRead3;
   logic       MemWrite3;
   logic       beq3;
   logic       bneq3;
   logic       J_type3;
   logic       PCsrc3;
   logic [1:0] WriteReg3;
   // WB controls
   logic [1:0] WriteReg4;
   logic       RegWrite4;
   // Forwarding selects and status
   logic [1:0] forward1;
   logic [1:0] forward2;
   logic       illegal;

   modport master (
      output op, func, rs, rt,
      output write_adress_reg_out, write_adress_reg2_out, zero_reg_out,
      input  ALUop2, ALUsrc2, RegDest2,
      input  MemRead3, MemWrite3, beq3, bneq3, J_type3, PCsrc3, WriteReg3,
      input  WriteReg4, RegWrite4,
      input  forward1, forward2, illegal
   );

   modport slave (
      input  op, func, rs, rt,
      input  write_adress_reg_out, write_adress_reg2_out, zero_reg_out,
      output ALUop2, ALUsrc2, RegDest2,
      output MemRead3, MemWrite3, beq3, bneq3, J_type3, PCsrc3, WriteReg3,
      output WriteReg4, RegWrite4,
      output forward1, forward2, illegal
   );
endinterface

// File: rtl/pipeline_controller.sv
// Five-stage MIPS pipeline control unit.
// Decodes the IF/ID instruction, carries the control word through EX (2),
// MEM (3) and WB (4), resolves branches/jumps in MEM with a squash of the
// wrong-path slots, and generates the ALU operand forwarding selects.
module pipeline_controller #(
   parameter int FETCH_DEPTH = 2
) (
   input logic               clk,
   input logic               rst,
   pipeline_controller_if.slave bus
);

   localparam int CW = (FETCH_DEPTH < 1) ? 1 : $clog2(FETCH_DEPTH + 1);
   localparam logic [CW-1:0] SQUASH_LOAD = CW'(FETCH_DEPTH);
   localparam logic [CW-1:0] SQUASH_ONE  = CW'(1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   // Control fields split by the stage that consumes them, so each stage
   // register only carries what is still needed downstream.
   typedef struct packed {
      logic [2:0] alu_op;
      logic       alu_src;
      logic [1:0] reg_dest;
   } ex_ctl_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic beq;
      logic bne;
      logic jmp;   // j or jal: absolute target
      logic jr;    // register target
   } mem_ctl_t;

   typedef struct packed {
      logic [1:0] write_reg;
      logic       reg_write;
   } wb_ctl_t;

   // Forwarding select for one EX operand. A MEM-stage match beats a WB
   // match; a MEM load forwards the memory read data directly (select 11),
   // so a load-use pair needs no stall. $0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic       v2,
      input logic       v3,
      input wb_ctl_t    wb3,
      input logic [4:0] wa3,
      input logic       v4,
      input wb_ctl_t    wb4,
      input logic [4:0] wa4
   );
      logic [1:0] sel;
      if (!v2 || (src == 5'd0)) begin
         sel = 2'b00;
      end else if (v3 && wb3.reg_write && (wa3 == src)) begin
         sel = (wb3.write_reg == 2'b10) ? 2'b11 : 2'b01;
      end else if (v4 && wb4.reg_write && (wa4 == src)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Decoder outputs
   logic     dec_valid_s;
   ex_ctl_t  dec_ex_s;
   mem_ctl_t dec_mem_s;
   wb_ctl_t  dec_wb_s;
   logic     dec_bad_s;

   // Stage registers
   logic     v2_q, v2_d;
   ex_ctl_t  ex2_q, ex2_d;
   mem_ctl_t mem2_q, mem2_d;
   wb_ctl_t  wb2_q, wb2_d;
   logic [4:0] rs2_q, rs2_d;
   logic [4:0] rt2_q, rt2_d;

   logic     v3_q, v3_d;
   mem_ctl_t mem3_q, mem3_d;
   wb_ctl_t  wb3_q, wb3_d;

   logic     v4_q, v4_d;
   wb_ctl_t  wb4_q, wb4_d;

   logic [CW-1:0] squash_q, squash_d;
   logic          illegal_q, illegal_d;

   logic       pcsrc_s;
   logic [1:0] fwd1_s;
   logic [1:0] fwd2_s;

   // Decode the IF/ID instruction; anything unrecognised becomes a bubble
   always_comb begin
      dec_valid_s = 1'b0;
      dec_ex_s    = '0;
      dec_mem_s   = '0;
      dec_wb_s    = '0;
      dec_bad_s   = 1'b0;
      case (bus.op)
         OP_RTYPE: begin
            case (bus.func)
               FN_ADD: begin
                  dec_valid_s        = 1'b1;
                  dec_ex_s.reg_dest  = 2'b01;
                  dec_wb_s.reg_write = 1'b1;
               end
               FN_SUB: begin
                  dec_valid_s        = 1'b1;
                  dec_ex_s.alu_op    = 3'b001;
                  dec_ex_s.reg_dest  = 2'b01;
                  dec_wb_s.reg_write = 1'b1;
               end
               FN_SLT: begin
                  dec_valid_s        = 1'b1;
                  dec_ex_s.alu_op    = 3'b001;
                  dec_ex_s.reg_dest  = 2'b01;
                  dec_wb_s.write_reg = 2'b01;
                  dec_wb_s.reg_write = 1'b1;
               end
               FN_JR: begin
                  dec_valid_s  = 1'b1;
                  dec_mem_s.jr = 1'b1;
               end
               default: begin
                  dec_bad_s = 1'b1;
               end
            endcase
         end
         OP_LW: begin
            dec_valid_s        = 1'b1;
            dec_ex_s.alu_src   = 1'b1;
            dec_mem_s.mem_read = 1'b1;
            dec_wb_s.write_reg = 2'b10;
            dec_wb_s.reg_write = 1'b1;
         end
         OP_SW: begin
            dec_valid_s         = 1'b1;
            dec_ex_s.alu_src    = 1'b1;
            dec_mem_s.mem_write = 1'b1;
         end
         OP_ADDI: begin
            dec_valid_s        = 1'b1;
            dec_ex_s.alu_src   = 1'b1;
            dec_wb_s.reg_write = 1'b1;
         end
         OP_BEQ: begin
            dec_valid_s     = 1'b1;
            dec_ex_s.alu_op = 3'b001;
            dec_mem_s.beq   = 1'b1;
         end
         OP_BNE: begin
            dec_valid_s     = 1'b1;
            dec_ex_s.alu_op = 3'b001;
            dec_mem_s.bne   = 1'b1;
         end
         OP_J: begin
            dec_valid_s   = 1'b1;
            dec_mem_s.jmp = 1'b1;
         end
         OP_JAL: begin
            dec_valid_s        = 1'b1;
            dec_ex_s.reg_dest  = 2'b10;
            dec_mem_s.jmp      = 1'b1;
            dec_wb_s.write_reg = 2'b11;
            dec_wb_s.reg_write = 1'b1;
         end
         default: begin
            dec_bad_s = 1'b1;
         end
      endcase
   end

   // Resolve the MEM-stage branch/jump against the registered zero flag
   always_comb begin
      pcsrc_s = v3_q & (mem3_q.jmp | mem3_q.jr
                        | (mem3_q.beq & bus.zero_reg_out)
                        | (mem3_q.bne & ~bus.zero_reg_out));
   end

   // Forwarding selects for both EX operands
   always_comb begin
      fwd1_s = fwd_sel(rs2_q, v2_q, v3_q, wb3_q, bus.write_adress_reg_out,
                       v4_q, wb4_q, bus.write_adress_reg2_out);
      fwd2_s = fwd_sel(rt2_q, v2_q, v3_q, wb3_q, bus.write_adress_reg_out,
                       v4_q, wb4_q, bus.write_adress_reg2_out);
   end

   // Next stage contents: shift down, bubbling the wrong-path slots on a redirect
   always_comb begin
      v4_d      = v3_q;
      wb4_d     = wb3_q;
      illegal_d = illegal_q | dec_bad_s;
      if (pcsrc_s) begin
         // EX and ID instructions are on the wrong path; the fetch slots
         // still in flight are squashed by the counter.
         v3_d     = 1'b0;
         mem3_d   = '0;
         wb3_d    = '0;
         v2_d     = 1'b0;
         ex2_d    = '0;
         mem2_d   = '0;
         wb2_d    = '0;
         rs2_d    = 5'd0;
         rt2_d    = 5'd0;
         squash_d = SQUASH_LOAD;
      end else if (squash_q != '0) begin
         v3_d     = v2_q;
         mem3_d   = mem2_q;
         wb3_d    = wb2_q;
         v2_d     = 1'b0;
         ex2_d    = '0;
         mem2_d   = '0;
         wb2_d    = '0;
         rs2_d    = 5'd0;
         rt2_d    = 5'd0;
         squash_d = squash_q - SQUASH_ONE;
      end else begin
         v3_d     = v2_q;
         mem3_d   = mem2_q;
         wb3_d    = wb2_q;
         v2_d     = dec_valid_s;
         ex2_d    = dec_ex_s;
         mem2_d   = dec_mem_s;
         wb2_d    = dec_wb_s;
         // A bubble carries no source registers, so it never forwards
         rs2_d    = dec_valid_s ? bus.rs : 5'd0;
         rt2_d    = dec_valid_s ? bus.rt : 5'd0;
         squash_d = squash_q;
      end
   end

   // Stage, squash and status registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         v2_q      <= 1'b0;
         ex2_q     <= '0;
         mem2_q    <= '0;
         wb2_q     <= '0;
         rs2_q     <= 5'd0;
         rt2_q     <= 5'd0;
         v3_q      <= 1'b0;
         mem3_q    <= '0;
         wb3_q     <= '0;
         v4_q      <= 1'b0;
         wb4_q     <= '0;
         squash_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         v2_q      <= v2_d;
         ex2_q     <= ex2_d;
         mem2_q    <= mem2_d;
         wb2_q     <= wb2_d;
         rs2_q     <= rs2_d;
         rt2_q     <= rt2_d;
         v3_q      <= v3_d;
         mem3_q    <= mem3_d;
         wb3_q     <= wb3_d;
         v4_q      <= v4_d;
         wb4_q     <= wb4_d;
         squash_q  <= squash_d;
         illegal_q <= illegal_d;
      end
   end

   // Stage outputs, each qualified by its stage valid bit
   always_comb begin
      bus.ALUop2    = ex2_q.alu_op & {3{v2_q}};
      bus.ALUsrc2   = ex2_q.alu_src & v2_q;
      bus.RegDest2  = ex2_q.reg_dest & {2{v2_q}};
      bus.MemRead3  = mem3_q.mem_read & v3_q;
      bus.MemWrite3 = mem3_q.mem_write & v3_q;
      bus.beq3      = mem3_q.beq & v3_q;
      bus.bneq3     = mem3_q.bne & v3_q;
      bus.J_type3   = mem3_q.jr & v3_q;
      bus.PCsrc3    = pcsrc_s;
      bus.WriteReg3 = wb3_q.write_reg & {2{v3_q}};
      bus.WriteReg4 = wb4_q.write_reg & {2{v4_q}};
      bus.RegWrite4 = wb4_q.reg_write & v4_q;
      bus.forward1  = fwd1_s;
      bus.forward2  = fwd2_s;
      bus.illegal   = illegal_q;
   end

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller. The stimulus process feeds one
// instruction per cycle, predicts that cycle's outputs from an
// instruction-history model (which cycle each instruction was decoded in,
// which ones were squashed) and queues the prediction; a monitor on the
// falling edge pops and compares against the DUT.
module tb_pipeline_controller;

   localparam int FD   = 2;
   localparam int MAXC = 2048;

   typedef enum int {
      K_ADD, K_SUB, K_SLT, K_JR, K_LW, K_SW, K_ADDI,
      K_BEQ, K_BNE, K_J, K_JAL, K_BADOP, K_BADFN
   } kind_t;

   typedef struct packed {
      logic [31:0] cyc;
      logic [2:0]  alu_op;
      logic        alu_src;
      logic [1:0]  reg_dest;
      logic        mem_read;
      logic        mem_write;
      logic        beq;
      logic        bne;
      logic        j_type;
      logic        pcsrc;
      logic [1:0]  wr3;
      logic [1:0]  wr4;
      logic        rw4;
      logic [1:0]  f1;
      logic [1:0]  f2;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   pipeline_controller_if bus ();

   pipeline_controller #(.FETCH_DEPTH(FD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Instruction history, indexed by the cycle it sat in IF/ID
   kind_t      s_kind [MAXC];
   logic [4:0] s_rs   [MAXC];
   logic [4:0] s_rt   [MAXC];
   logic [4:0] s_rd   [MAXC];
   bit         s_dead [MAXC];

   int   cyc        = 0;
   int   kill_until = -1;
   bit   ill_m      = 1'b0;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   function automatic bit legal(kind_t k);
      return (k != K_BADOP) && (k != K_BADFN);
   endfunction

   function automatic bit writes_reg(kind_t k);
      return k inside {K_ADD, K_SUB, K_SLT, K_LW, K_ADDI, K_JAL};
   endfunction

   function automatic logic [2:0] m_aluop(kind_t k);
      return (k inside {K_SUB, K_SLT, K_BEQ, K_BNE}) ? 3'b001 : 3'b000;
   endfunction

   function automatic logic [1:0] m_regdest(kind_t k);
      if (k inside {K_ADD, K_SUB, K_SLT}) return 2'b01;
      if (k == K_JAL) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [1:0] m_wbsrc(kind_t k);
      if (k == K_SLT) return 2'b01;
      if (k == K_LW)  return 2'b10;
      if (k == K_JAL) return 2'b11;
      return 2'b00;
   endfunction

   function automatic bit m_taken(kind_t k, logic z);
      return (k inside {K_J, K_JAL, K_JR}) || (k == K_BEQ && z) || (k == K_BNE && !z);
   endfunction

   function automatic bit alive(int s);
      return (s >= 0) && !s_dead[s];
   endfunction

   // Where the EX instruction (decoded at c-1) gets one operand from
   function automatic logic [1:0] m_fwd(int c, bit use_rt, logic [4:0] wa3, logic [4:0] wa4);
      logic [4:0] src;
      if (!alive(c - 1)) return 2'b00;
      src = use_rt ? s_rt[c-1] : s_rs[c-1];
      if (src == 5'd0) return 2'b00;
      if (alive(c - 2) && writes_reg(s_kind[c-2]) && wa3 == src)
         return (s_kind[c-2] == K_LW) ? 2'b11 : 2'b01;
      if (alive(c - 3) && writes_reg(s_kind[c-3]) && wa4 == src)
         return 2'b10;
      return 2'b00;
   endfunction

   task automatic encode(input kind_t k, output logic [5:0] op, output logic [5:0] fn);
      op = 6'b000000;
      fn = 6'($urandom_range(0, 63));
      case (k)
         K_ADD:   fn = 6'b100000;
         K_SUB:   fn = 6'b100010;
         K_SLT:   fn = 6'b101010;
         K_JR:    fn = 6'b001000;
         K_BADFN: fn = 6'b000111;
         K_LW:    op = 6'b100011;
         K_SW:    op = 6'b101011;
         K_ADDI:  op = 6'b001000;
         K_BEQ:   op = 6'b000100;
         K_BNE:   op = 6'b000101;
         K_J:     op = 6'b000010;
         K_JAL:   op = 6'b000011;
         default: op = 6'b111111;
      endcase
   endtask

   // One cycle: drive the IF/ID instruction and datapath inputs, queue the prediction
   task automatic step(input kind_t k, input logic [4:0] rs_v, input logic [4:0] rt_v,
                       input logic [4:0] rd_v, input logic z, input logic rst_v);
      exp_t       e;
      int         c;
      logic [4:0] wa3;
      logic [4:0] wa4;
      logic [5:0] op_v;
      logic [5:0] fn_v;
      bit         redirect;
      @(posedge clk);
      #1;
      c = cyc;
      if (c >= MAXC) begin
         $display("FAIL history_overflow cycle %0d exceeds %0d", c, MAXC);
         $fatal(1);
      end
      wa3 = (c >= 2) ? s_rd[c-2] : 5'd0;
      wa4 = (c >= 3) ? s_rd[c-3] : 5'd0;
      encode(k, op_v, fn_v);
      rst                       = rst_v;
      bus.op                    = op_v;
      bus.func                  = fn_v;
      bus.rs                    = rs_v;
      bus.rt                    = rt_v;
      bus.write_adress_reg_out  = wa3;
      bus.write_adress_reg2_out = wa4;
      bus.zero_reg_out          = z;

      s_kind[c] = k;
      s_rs[c]   = rs_v;
      s_rt[c]   = rt_v;
      s_rd[c]   = rd_v;
      s_dead[c] = !legal(k) || (c <= kill_until);

      e        = '0;
      e.cyc    = 32'(c);
      redirect = 1'b0;
      if (alive(c - 1)) begin
         e.alu_op   = m_aluop(s_kind[c-1]);
         e.alu_src  = s_kind[c-1] inside {K_LW, K_SW, K_ADDI};
         e.reg_dest = m_regdest(s_kind[c-1]);
      end
      if (alive(c - 2)) begin
         redirect    = m_taken(s_kind[c-2], z);
         e.mem_read  = (s_kind[c-2] == K_LW);
         e.mem_write = (s_kind[c-2] == K_SW);
         e.beq       = (s_kind[c-2] == K_BEQ);
         e.bne       = (s_kind[c-2] == K_BNE);
         e.j_type    = (s_kind[c-2] == K_JR);
         e.pcsrc     = redirect;
         e.wr3       = m_wbsrc(s_kind[c-2]);
      end
      if (alive(c - 3)) begin
         e.wr4 = m_wbsrc(s_kind[c-3]);
         e.rw4 = writes_reg(s_kind[c-3]);
      end
      e.f1  = m_fwd(c, 1'b0, wa3, wa4);
      e.f2  = m_fwd(c, 1'b1, wa3, wa4);
      e.ill = ill_m;
      exp_q.push_back(e);

      // A taken redirect kills the EX and ID instructions and the next FD fetches
      if (redirect) begin
         s_dead[c-1] = 1'b1;
         s_dead[c]   = 1'b1;
         kill_until  = c + FD;
      end
      ill_m = rst_v ? (ill_m | !legal(k)) : 1'b0;
      if (!rst_v) begin
         for (int s = c - 2; s <= c; s++) begin
            if (s >= 0) s_dead[s] = 1'b1;
         end
         kill_until = c;
      end
      cyc++;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(K_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
   endtask

   task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] expv);
      n_checks++;
      if (act === expv) begin
         n_pass++;
      end else begin
         $display("FAIL %s cycle %0d: got %0h, expected %0h", name, c, act, expv);
      end
   endtask

   // Monitor: compare the DUT against the queued prediction mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("ex_ctl", int'(e.cyc), {2'b00, bus.ALUop2, bus.ALUsrc2, bus.RegDest2},
             {2'b00, e.alu_op, e.alu_src, e.reg_dest});
         chk("mem_ctl", int'(e.cyc), {bus.MemRead3, bus.MemWrite3, bus.beq3, bus.bneq3,
             bus.J_type3, bus.PCsrc3, bus.WriteReg3},
             {e.mem_read, e.mem_write, e.beq, e.bne, e.j_type, e.pcsrc, e.wr3});
         chk("wb_ctl", int'(e.cyc), {5'b00000, bus.WriteReg4, bus.RegWrite4},
             {5'b00000, e.wr4, e.rw4});
         chk("forward1", int'(e.cyc), {6'b000000, bus.forward1}, {6'b000000, e.f1});
         chk("forward2", int'(e.cyc), {6'b000000, bus.forward2}, {6'b000000, e.f2});
         chk("illegal", int'(e.cyc), {7'b0000000, bus.illegal}, {7'b0000000, e.ill});
      end
   end

   initial begin
      kind_t k;
      bus.op = 6'b100011;  bus.func = 6'b000000;
      bus.rs = 5'd0;       bus.rt = 5'd0;
      bus.write_adress_reg_out = 5'd0;
      bus.write_adress_reg2_out = 5'd0;
      bus.zero_reg_out = 1'b0;

      // Reset held with lw presented, then release; lw reaches MEM two cycles later
      step(K_LW, 5'd1, 5'd2, 5'd2, 1'b0, 1'b0);
      step(K_LW, 5'd1, 5'd2, 5'd2, 1'b0, 1'b0);
      step(K_LW, 5'd1, 5'd2, 5'd2, 1'b0, 1'b1);
      nop(3);

      // add r3,r1,r2 ; sub r4,r3,r5 ; add r6,r3,r0
      step(K_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
      step(K_SUB, 5'd3, 5'd5, 5'd4, 1'b0, 1'b1);
      step(K_ADD, 5'd3, 5'd0, 5'd6, 1'b0, 1'b1);
      nop(3);

      // lw r2,0(r1) ; add r4,r2,r2 (load-use) ; write $0 then read $0
      step(K_LW,  5'd1, 5'd2, 5'd2, 1'b0, 1'b1);
      step(K_ADD, 5'd2, 5'd2, 5'd4, 1'b0, 1'b1);
      step(K_ADD, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1);
      step(K_ADD, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1);
      nop(3);

      // Taken beq followed by five adds: four squashed, fifth survives
      step(K_BEQ, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(K_ADD, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
      nop(3);

      // Not-taken bne
      step(K_BNE, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(K_ADD, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
      nop(1);

      // jal then jr r31
      step(K_JAL, 5'd0, 5'd0, 5'd31, 1'b0, 1'b1);
      nop(4);
      step(K_JR, 5'd31, 5'd0, 5'd0, 1'b0, 1'b1);
      nop(4);

      // Undecodable opcode and func, a later add, then reset clears illegal
      step(K_BADOP, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
      step(K_ADD, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1);
      nop(3);
      step(K_BADFN, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
      nop(2);
      step(K_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      nop(3);

      // Randomised instruction stream with occasional bad encodings and resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 63) == 0)
            k = ($urandom_range(0, 1) == 0) ? K_BADOP : K_BADFN;
         else
            k = kind_t'($urandom_range(0, 10));
         step(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
      end
      nop(4);

      // Every queued prediction must have been consumed by the monitor
      repeat (3) @(posedge clk);
      n_checks++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Control unit for the five-stage MIPS pipeline datapath. It decodes the instruction held in the IF/ID register and carries the control word down through the EX (2), MEM (3) and WB (4) stages. It resolves branches and jumps in MEM and squashes wrong-path instructions, and it drives the forwarding selects for both ALU operands. It produces every control input the datapath consumes.

## Interface
Parameters:
- FETCH_DEPTH, 2, number of fetch slots squashed after a redirect, beyond the ID and EX instructions (covers the synchronous instruction memory plus the IF/ID register).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous and active-low; sampled only on the rising edge of clk.
- op, func  in  6 each  instruction fields [31:26] and [5:0] of the IF/ID instruction.
- rs, rt  in  5 each  fields [25:21] and [20:16] of the IF/ID instruction.
- write_adress_reg_out, write_adress_reg2_out  in  5 each  destination registers of the MEM and WB stages.
- zero_reg_out  in  1  registered ALU zero of the MEM-stage instruction.
- ALUop2  out  3  EX ALU operation: 000 add, 001 sub.
- ALUsrc2  out  1  ALU B source: 1 = sign-extended immediate.
- RegDest2  out  2  destination select: 00 rt, 01 rd, 10 $31.
- MemRead3, MemWrite3, beq3, bneq3  out  1 each  MEM-stage controls.
- J_type3  out  1  jump target select in MEM: 1 = register (jr), 0 = {pc[31:28], imm26, 00}.
- PCsrc3  out  1  redirect the PC in this cycle.
- WriteReg3, WriteReg4  out  2 each  writeback source for MEM and WB: 00 ALU, 01 slt bit, 10 memory, 11 link (pc).
- RegWrite4  out  1  register-file write enable in WB.
- forward1, forward2  out  2 each  EX operand source: 00 register, 01 MEM result, 10 WB result, 11 memory read data.
- illegal  out  1  sticky flag, set on an undecodable opcode or func.

## Operation
- Decode, combinational from op/func:
  - R-type (op 000000), func 100000 add, 100010 sub, 101010 slt (ALUop sub, WriteReg 01), 001000 jr.
  - lw 100011, sw 101011, addi 001000, beq 000100, bne 000101, j 000010, jal 000011.
  - add/sub/slt: RegDest 01, RegWrite 1. addi/lw: RegDest 00, ALUsrc 1. lw: MemRead 1, WriteReg 10. sw: ALUsrc 1, MemWrite 1, RegWrite 0. beq/bne: ALUop 001, ALUsrc 0. jal: RegDest 10, WriteReg 11, RegWrite 1.
- Any other encoding decodes as a bubble (all controls 0) and sets illegal. Only reset clears illegal.
- Control registers ctl2, ctl3 and ctl4 each hold a valid bit and the control fields. ctl2 also holds rs and rt. Each clock, ctl4←ctl3, ctl3←ctl2, ctl2←decode.
- Each output is driven from its stage register ANDed with that stage's valid bit.
- Redirect: PCsrc3 = valid3 & (j | jal | jr | (beq3 & zero_reg_out) | (bneq3 & ~zero_reg_out)). J_type3 = valid3 & jr.
- On an edge where PCsrc3 = 1:
  - ctl3←bubble, because the EX instruction is on the wrong path.
  - ctl2←bubble, because the ID instruction is on the wrong path.
  - squash_cnt←FETCH_DEPTH.
- While squash_cnt ≠ 0, ctl2 loads a bubble and squash_cnt decrements. No redirect can occur during this window, because bubbles carry no branch.
- Forwarding for operand A, using rs2 (operand B is identical, using rt2). Evaluate in priority order:
  - 11 if valid3, RegWrite3 = 1, write_adress_reg_out = rs2, rs2 ≠ 0 and WriteReg3 = 10.
  - else 01 under the same match with WriteReg3 ≠ 10.
  - else 10 if valid4, RegWrite4 = 1, write_adress_reg2_out = rs2 and rs2 ≠ 0.
  - else 00.
- Register $0 is never forwarded. The MEM match beats the WB match. A load-use pair needs no stall, because select 11 forwards the memory read data in the same cycle.

## Timing
- Reset: on a clk edge with rst = 0, every ctl valid bit, squash_cnt and illegal clear. From the next cycle, every output is 0, including forward1/2 = 00. Reset mid-redirect also cancels any pending squash.
- Latency: the instruction decoded in cycle t drives the EX outputs in t+1, the MEM outputs in t+2 and the WB outputs in t+3.
- PCsrc3 is high for exactly one cycle per taken redirect. The four younger slots (ID, EX and FETCH_DEPTH fetch slots) never assert RegWrite4, MemWrite3, MemRead3 or PCsrc3.
- forward1/2 are combinational from the stage registers and the inputs, and are valid in the same cycle as ALUop2.
- illegal rises in the cycle after the bad instruction is decoded, and stays high until reset.

## Test plan
- Hold rst = 0 for 2 cycles with op = 100011 → all outputs 0. Release rst → the first lw gives MemRead3 = 1 two cycles later.
- add r3,r1,r2 then sub r4,r3,r5 then add r6,r3,r0 → forward1 = 01 while the sub is in EX, then forward1 = 10 while the third instruction is in EX. forward2 = 00 throughout.
- lw r2,0(r1) then add r4,r2,r2 → forward1 = forward2 = 11 and MemRead3 = 1 in the same cycle. Write to $0 then read $0 → forward stays 00.
- beq with zero_reg_out = 1 followed by 4 add instructions → PCsrc3 = 1 for 1 cycle, J_type3 = 0. None of the 4 adds produces RegWrite4 = 1. The 5th add writes normally.
- bne with zero_reg_out = 1 → PCsrc3 = 0 and no squash. jal → RegDest2 = 10, PCsrc3 = 1, then WriteReg4 = 11 with RegWrite4 = 1. jr r31 → J_type3 = 1 with PCsrc3 = 1.
- op = 111111 → illegal = 1 with no control asserted for that slot. A later valid add behaves normally. rst = 0 clears illegal.
